// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_burst_ctr.sv
// DMA burst bookkeeping: next beat address and beats still to go.
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  // Beat 0 is issued from start_addr directly, so the register holds start+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= start_addr + ADDR_W'(1);
      remaining <= len;
    end else if (step) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store unit and a burst-capable DMA engine.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_next;
  req_id_t           last_grant, last_grant_next;
  logic              burst_we;
  logic              done_next;
  logic              ctr_load, ctr_step, ctr_last;
  logic [ADDR_W-1:0] ctr_addr;
  logic              pick_cpu;

  dmem_burst_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_burst_ctr (
    .clk        (clk),
    .reset      (reset),
    .load       (ctr_load),
    .start_addr (dma_addr),
    .len        (dma_len),
    .step       (ctr_step),
    .addr       (ctr_addr),
    .last       (ctr_last)
  );

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    cpu_gnt         = 1'b0;
    dma_gnt         = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    ctr_load        = 1'b0;
    ctr_step        = 1'b0;
    done_next       = 1'b0;
    // On a tie the CPU wins unless it was the most recent grantee.
    pick_cpu        = cpu_req && (!dma_req || (last_grant == REQ_DMA));
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (pick_cpu) begin
            cpu_gnt         = 1'b1;
            mem_read        = !cpu_we;
            mem_write       = cpu_we;
            mem_addr        = cpu_addr;
            mem_wdata       = cpu_wdata;
            last_grant_next = REQ_CPU;
          end else if (dma_req) begin
            dma_gnt         = 1'b1;
            mem_read        = !dma_we;
            mem_write       = dma_we;
            mem_addr        = dma_addr;
            mem_wdata       = dma_wdata;
            ctr_load        = 1'b1;
            last_grant_next = REQ_DMA;
            if (dma_len != '0) state_next = BURST;
            else               done_next  = 1'b1;
          end
        end
        BURST: begin
          if (dma_req) begin
            dma_gnt   = 1'b1;
            mem_read  = !burst_we;
            mem_write = burst_we;
            mem_addr  = ctr_addr;
            mem_wdata = dma_wdata;
            ctr_step  = 1'b1;
            if (ctr_last) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_DMA;
      burst_we   <= 1'b0;
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if (ctr_load) burst_we <= dma_we;
      cpu_rvalid <= cpu_gnt && mem_read;
      if (cpu_gnt && mem_read) cpu_rdata <= mem_rdata;
      dma_rvalid <= dma_gnt && mem_read;
      if (dma_gnt && mem_read) dma_rdata <= mem_rdata;
      dma_done   <= done_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for burst
// corner cases, then random traffic against a transaction-level model.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_done;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_len;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Memory: 256 words indexed by addr[7:0], combinational read.
  logic [31:0] tb_mem [256];
  logic        mem_init;
  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
    end else if (mem_write) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, creq, cwe; logic [31:0] caddr, cwd;
    logic dreq, dwe; logic [31:0] daddr; logic [3:0] dlen; logic [31:0] dwd;
    logic e_cg, e_dg, e_rd, e_wr; logic [31:0] e_addr;
    logic e_crv; logic [31:0] e_crd; logic e_drv; logic [31:0] e_drd;
    logic e_done, e_zero;
  } row_t;

  function automatic row_t req_row(logic creq, logic cwe, logic [31:0] caddr, logic [31:0] cwd,
                                   logic dreq, logic dwe, logic [31:0] daddr, logic [3:0] dlen,
                                   logic [31:0] dwd);
    row_t r = '{default: '0};
    r.creq = creq; r.cwe = cwe; r.caddr = caddr; r.cwd = cwd;
    r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dlen = dlen; r.dwd = dwd;
    return r;
  endfunction

  function automatic row_t exp_comb(row_t r, logic cg, logic dg, logic rd, logic wr, logic [31:0] addr);
    row_t o = r;
    o.e_cg = cg; o.e_dg = dg; o.e_rd = rd; o.e_wr = wr; o.e_addr = addr;
    return o;
  endfunction

  function automatic row_t exp_reg(row_t r, logic crv, logic [31:0] crd, logic drv, logic [31:0] drd, logic done);
    row_t o = r;
    o.e_crv = crv; o.e_crd = crd; o.e_drv = drv; o.e_drd = drd; o.e_done = done;
    return o;
  endfunction

  function automatic row_t idle_row();
    return req_row(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply_row(input row_t r, input string tag);
    @(negedge clk);
    reset = r.rst;
    cpu_req = r.creq; cpu_we = r.cwe; cpu_addr = r.caddr; cpu_wdata = r.cwd;
    dma_req = r.dreq; dma_we = r.dwe; dma_addr = r.daddr; dma_len = r.dlen; dma_wdata = r.dwd;
    #1;
    chk($sformatf("%s cpu_gnt", tag), 32'(cpu_gnt), 32'(r.e_cg));
    chk($sformatf("%s dma_gnt", tag), 32'(dma_gnt), 32'(r.e_dg));
    chk($sformatf("%s mem_read", tag), 32'(mem_read), 32'(r.e_rd));
    chk($sformatf("%s mem_write", tag), 32'(mem_write), 32'(r.e_wr));
    if (r.e_rd || r.e_wr) chk($sformatf("%s mem_addr", tag), mem_addr, r.e_addr);
    chk($sformatf("%s cpu_rvalid", tag), 32'(cpu_rvalid), 32'(r.e_crv));
    chk($sformatf("%s dma_rvalid", tag), 32'(dma_rvalid), 32'(r.e_drv));
    chk($sformatf("%s dma_done", tag), 32'(dma_done), 32'(r.e_done));
    if (r.e_crv || r.e_zero) chk($sformatf("%s cpu_rdata", tag), cpu_rdata, r.e_crd);
    if (r.e_drv || r.e_zero) chk($sformatf("%s dma_rdata", tag), dma_rdata, r.e_drd);
  endtask

  // Random-phase reference model state.
  logic [31:0] ref_mem [256];
  logic        m_burst, m_cpu_last, m_we;
  int          m_left;
  logic [31:0] m_addr;
  logic        x_crv, x_drv, x_done;
  logic [31:0] x_crd, x_drd;
  logic        e_cg, e_dg, e_rd, e_wr;
  logic [31:0] e_addr, e_wd;
  logic        cpu_pend, dma_hold;

  row_t tbl [17];
  row_t r;

  initial begin
    reset = 1; mem_init = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
    repeat (2) @(negedge clk);
    mem_init = 0;

    tbl[0]  = req_row(1, 0, 'h30, 0, 1, 0, 'h20, 0, 0);
    tbl[0].rst = 1; tbl[0].e_zero = 1;
    tbl[1]  = exp_comb(req_row(1, 0, 'h30, 0, 1, 0, 'h20, 0, 0), 1, 0, 1, 0, 'h30);
    tbl[2]  = exp_reg(exp_comb(req_row(0, 0, 0, 0, 1, 0, 'h20, 0, 0), 0, 1, 1, 0, 'h20),
                      1, init_word('h30), 0, 0, 0);
    tbl[3]  = exp_reg(idle_row(), 0, 0, 1, init_word('h20), 1);
    tbl[4]  = exp_comb(req_row(1, 1, 'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0), 1, 0, 0, 1, 'h10);
    tbl[5]  = exp_comb(req_row(1, 0, 'h10, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'h10);
    tbl[6]  = exp_reg(idle_row(), 1, 32'hDEADBEEF, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      tbl[7+k] = exp_comb(req_row(0, 0, 0, 0, 1, 1, 'hFE, 3, 32'(k+1)), 0, 1, 0, 1, 32'hFE + 32'(k));
    tbl[11] = exp_reg(idle_row(), 0, 0, 0, 0, 1);
    tbl[12] = exp_comb(req_row(1, 0, 'hFE, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'hFE);
    tbl[13] = exp_reg(exp_comb(req_row(1, 0, 'hFF, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'hFF), 1, 1, 0, 0, 0);
    tbl[14] = exp_reg(exp_comb(req_row(1, 0, 'h00, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'h00), 1, 2, 0, 0, 0);
    tbl[15] = exp_reg(exp_comb(req_row(1, 0, 'h01, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'h01), 1, 3, 0, 0, 0);
    tbl[16] = exp_reg(idle_row(), 1, 4, 0, 0, 0);
    for (int i = 0; i < 17; i++) apply_row(tbl[i], $sformatf("vec%0d", i));

    // Read burst len=7; CPU request arrives at beat 2 and must wait.
    for (int k = 0; k < 8; k++) begin
      r = exp_comb(req_row(k >= 2, 0, 'h05, 0, 1, 0, 'h40, 7, 0), 0, 1, 1, 0, 32'h40 + 32'(k));
      apply_row(exp_reg(r, 0, 0, k >= 1, init_word('h40 + k - 1), 0), $sformatf("rdburst b%0d", k));
    end
    r = exp_comb(req_row(1, 0, 'h05, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'h05);
    apply_row(exp_reg(r, 0, 0, 1, init_word('h47), 1), "rdburst end");
    apply_row(exp_reg(idle_row(), 1, init_word('h05), 0, 0, 0), "rdburst cpu");

    // len=5 burst aborted after beat 2.
    for (int k = 0; k < 3; k++) begin
      r = exp_comb(req_row(0, 0, 0, 0, 1, 0, 'h60, 5, 0), 0, 1, 1, 0, 32'h60 + 32'(k));
      apply_row(exp_reg(r, 0, 0, k >= 1, init_word('h60 + k - 1), 0), $sformatf("abort b%0d", k));
    end
    apply_row(exp_reg(idle_row(), 0, 0, 1, init_word('h62), 0), "abort drop");
    r = exp_comb(req_row(1, 0, 'h07, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'h07);
    apply_row(exp_reg(r, 0, 0, 0, 0, 1), "abort idle");
    apply_row(exp_reg(idle_row(), 1, init_word('h07), 0, 0, 0), "abort cpu");

    // Reset lands on beat 3 of a burst.
    for (int k = 0; k < 3; k++) begin
      r = exp_comb(req_row(0, 0, 0, 0, 1, 0, 'h80, 7, 0), 0, 1, 1, 0, 32'h80 + 32'(k));
      apply_row(exp_reg(r, 0, 0, k >= 1, init_word('h80 + k - 1), 0), $sformatf("rstb b%0d", k));
    end
    r = req_row(0, 0, 0, 0, 1, 0, 'h80, 7, 0);
    r.rst = 1;
    apply_row(exp_reg(r, 0, 0, 1, init_word('h82), 0), "rstb reset");
    r = idle_row(); r.e_zero = 1;
    apply_row(r, "rstb after");
    apply_row(exp_comb(req_row(1, 0, 'h10, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 'h10), "rstb cpu");
    apply_row(exp_reg(idle_row(), 1, 32'hDEADBEEF, 0, 0, 0), "rstb cpu data");

    // Random traffic.
    @(negedge clk);
    reset = 1; mem_init = 1;
    cpu_req = 0; dma_req = 0;
    @(negedge clk);
    mem_init = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    m_burst = 0; m_cpu_last = 0; m_we = 0; m_left = 0; m_addr = 0;
    x_crv = 0; x_drv = 0; x_done = 0; x_crd = 0; x_drd = 0;
    cpu_pend = 0; dma_hold = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd cpu_rvalid", 32'(cpu_rvalid), 32'(x_crv));
      chk("rnd cpu_rdata", cpu_rdata, x_crd);
      chk("rnd dma_rvalid", 32'(dma_rvalid), 32'(x_drv));
      chk("rnd dma_rdata", dma_rdata, x_drd);
      chk("rnd dma_done", 32'(dma_done), 32'(x_done));
      reset = 0;

      if (!cpu_pend) begin
        if ($urandom_range(0, 99) < 35) begin
          cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = $urandom; cpu_wdata = $urandom; cpu_pend = 1;
        end else cpu_req = 0;
      end
      dma_wdata = $urandom;
      if (!dma_hold) begin
        if ($urandom_range(0, 99) < 25) begin
          dma_req = 1; dma_we = 1'($urandom_range(0, 1));
          dma_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
          dma_len = 4'($urandom_range(0, 15)); dma_hold = 1;
        end else dma_req = 0;
      end else if (m_burst && $urandom_range(0, 15) == 0) begin
        dma_req = 0; dma_hold = 0;
      end
      #1;

      e_cg = 0; e_dg = 0; e_rd = 0; e_wr = 0; e_addr = 0; e_wd = 0;
      if (!m_burst) begin
        if (cpu_req && (!dma_req || !m_cpu_last)) begin
          e_cg = 1; e_rd = !cpu_we; e_wr = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
        end else if (dma_req) begin
          e_dg = 1; e_rd = !dma_we; e_wr = dma_we; e_addr = dma_addr; e_wd = dma_wdata;
        end
      end else if (dma_req) begin
        e_dg = 1; e_rd = !m_we; e_wr = m_we; e_addr = m_addr; e_wd = dma_wdata;
      end
      chk("rnd cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
      chk("rnd dma_gnt", 32'(dma_gnt), 32'(e_dg));
      chk("rnd mem_read", 32'(mem_read), 32'(e_rd));
      chk("rnd mem_write", 32'(mem_write), 32'(e_wr));
      chk("rnd mem_addr", mem_addr, e_addr);
      if (e_wr) chk("rnd mem_wdata", mem_wdata, e_wd);

      x_crv = e_cg && e_rd;
      x_drv = e_dg && e_rd;
      if (x_crv) x_crd = ref_mem[e_addr[7:0]];
      if (x_drv) x_drd = ref_mem[e_addr[7:0]];
      if (e_wr) ref_mem[e_addr[7:0]] = e_wd;
      x_done = 0;
      if (e_cg) begin
        m_cpu_last = 1; cpu_pend = 0;
      end
      if (!m_burst) begin
        if (e_dg) begin
          m_cpu_last = 0; m_we = dma_we; m_addr = dma_addr + 1; m_left = int'(dma_len);
          if (m_left == 0) begin x_done = 1; dma_hold = 0; end
          else m_burst = 1;
        end
      end else if (e_dg) begin
        m_addr = m_addr + 1; m_left = m_left - 1;
        if (m_left == 0) begin m_burst = 0; x_done = 1; dma_hold = 0; end
      end else begin
        m_burst = 0; x_done = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
